execute_unit: RTL and testbench

Integer execute stage: consumes the registered decode-stage outputs (operands, ALU control, destination, memory and branch/jump controls) and produces the EX/MEM pipeline register. It also drives the forwarding value back to decode, resolves branches and jumps into a fetch redirect/flush, and runs a 32-iteration multicycle divider that stalls the front end while busy. It sits between decode and the memory/writeback stage.

---
 rtl/execute_unit.sv | 192 +++++++++++++++++++
 tb/tb_execute_unit.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_unit.sv
// Integer execute stage: single-cycle ALU, branch resolution, 32-step restoring divider, EX/MEM register.
// Single-cycle ops register after one edge; divides hold EX for 34 cycles with ex_nstall low for the first 33.
module execute_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dec_op1,
  input  logic [31:0] dec_op2,
  input  logic [6:0]  aluctl,
  input  logic [6:0]  dec_rd,
  input  logic        dec_mre,
  input  logic        dec_mwe,
  input  logic [6:0]  dec_branch,
  input  logic        dec_jump,
  input  logic [24:0] npc,
  input  logic [29:0] daddr,
  input  logic        mem_ready,
  output logic [31:0] alu_fwd,
  output logic        ex_nstall,
  output logic        ex_flush,
  output logic [24:0] ex_pc,
  output logic [31:0] ex_res,
  output logic [31:0] ex_wdata,
  output logic [6:0]  ex_rd,
  output logic        ex_mre,
  output logic        ex_mwe,
  output logic [29:0] ex_daddr
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic       s_bit;
  logic [2:0] op, funct;
  logic [4:0] shamt;
  logic       is_div;

  assign s_bit  = aluctl[6];
  assign op     = aluctl[5:3];
  assign funct  = aluctl[2:0];
  assign shamt  = dec_op2[4:0];
  assign is_div = (op == 3'b001) && funct[2];

  // Low 64 bits of the product of sign-extended operands give both mul and mulh.
  logic [63:0] op1_sx, op2_sx, prod;
  logic [31:0] sra_res, sum;

  assign op1_sx  = {{32{dec_op1[31]}}, dec_op1};
  assign op2_sx  = {{32{dec_op2[31]}}, dec_op2};
  assign prod    = op1_sx * op2_sx;
  assign sra_res = $signed(dec_op1) >>> shamt;
  assign sum     = dec_op1 + dec_op2;

  always_comb begin
    alu_fwd = 32'd0;
    case (op)
      3'b000, 3'b100: begin
        case (funct)
          3'b000:  alu_fwd = (s_bit && op == 3'b000) ? dec_op1 - dec_op2 : sum;
          3'b001:  alu_fwd = dec_op1 << shamt;
          3'b010:  alu_fwd = {31'd0, $signed(dec_op1) < $signed(dec_op2)};
          3'b011:  alu_fwd = {31'd0, dec_op1 < dec_op2};
          3'b100:  alu_fwd = dec_op1 ^ dec_op2;
          3'b101:  alu_fwd = s_bit ? sra_res : dec_op1 >> shamt;
          3'b110:  alu_fwd = dec_op1 | dec_op2;
          default: alu_fwd = dec_op1 & dec_op2;
        endcase
      end
      3'b001: begin
        if (funct == 3'b000)      alu_fwd = prod[31:0];
        else if (funct == 3'b001) alu_fwd = prod[63:32];
        else                      alu_fwd = 32'd0;
      end
      3'b010, 3'b011: alu_fwd = dec_op1;
      3'b101:  alu_fwd = (funct == 3'b010) ? dec_op2 : sum;
      3'b110:  alu_fwd = 32'd0;
      default: alu_fwd = sum;
    endcase
  end

  // Branch resolution
  logic [5:0] cond;
  logic       taken, redirect;

  assign cond = {dec_op1 >= dec_op2,
                 dec_op1 <  dec_op2,
                 $signed(dec_op1) >= $signed(dec_op2),
                 $signed(dec_op1) <  $signed(dec_op2),
                 dec_op1 != dec_op2,
                 dec_op1 == dec_op2};
  assign taken    = dec_branch[6] && |(dec_branch[5:0] & cond);
  assign redirect = taken || dec_jump;
  assign ex_pc    = npc;
  assign ex_flush = redirect && ex_nstall && mem_ready;

  // Divider: magnitudes divided unsigned, signs reapplied once the 32 steps finish.
  logic [1:0]  state;
  logic [4:0]  count;
  logic [31:0] quo, dvs, rem;
  logic        neg_q, neg_r, want_rem;
  logic        sgn_div;
  logic [31:0] a_abs, b_abs;
  logic [33:0] trial;
  logic [31:0] quo_n, rem_n;
  logic [31:0] q_fix, r_fix, div_res;

  assign sgn_div = ~funct[0];
  assign a_abs   = (sgn_div && dec_op1[31]) ? -dec_op1 : dec_op1;
  assign b_abs   = (sgn_div && dec_op2[31]) ? -dec_op2 : dec_op2;

  assign trial = {1'b0, rem, quo[31]} - {2'b00, dvs};

  always_comb begin
    if (!trial[33]) begin
      rem_n = trial[31:0];
      quo_n = {quo[30:0], 1'b1};
    end else begin
      rem_n = {rem[30:0], quo[31]};
      quo_n = {quo[30:0], 1'b0};
    end
  end

  // A zero divisor naturally leaves quo all ones and rem = |dividend|.
  assign q_fix   = neg_q ? -quo : quo;
  assign r_fix   = neg_r ? -rem : rem;
  assign div_res = want_rem ? r_fix : q_fix;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      count <= 5'd0;
    end else begin
      case (state)
        S_IDLE: if (is_div) begin
          state <= S_BUSY;
          count <= 5'd0;
        end
        S_BUSY: begin
          count <= count + 5'd1;
          if (count == 5'd31) state <= S_DONE;
        end
        S_DONE: if (mem_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_IDLE && is_div) begin
      quo      <= a_abs;
      dvs      <= b_abs;
      rem      <= 32'd0;
      neg_q    <= sgn_div && (dec_op1[31] ^ dec_op2[31]) && (dec_op2 != 32'd0);
      neg_r    <= sgn_div && dec_op1[31];
      want_rem <= funct[1];
    end else if (state == S_BUSY) begin
      quo <= quo_n;
      rem <= rem_n;
    end
  end

  assign ex_nstall = !((state == S_BUSY) || (state == S_IDLE && is_div));

  // EX/MEM pipeline register
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_res   <= 32'd0;
      ex_wdata <= 32'd0;
      ex_rd    <= 7'd0;
      ex_mre   <= 1'b0;
      ex_mwe   <= 1'b0;
      ex_daddr <= 30'd0;
    end else if (mem_ready) begin
      if (ex_nstall) begin
        ex_res   <= is_div ? div_res : alu_fwd;
        ex_wdata <= dec_op2;
        ex_rd    <= dec_rd;
        ex_mre   <= dec_mre;
        ex_mwe   <= dec_mwe;
        ex_daddr <= daddr;
      end else begin
        ex_res   <= 32'd0;
        ex_wdata <= 32'd0;
        ex_rd    <= 7'd0;
        ex_mre   <= 1'b0;
        ex_mwe   <= 1'b0;
        ex_daddr <= 30'd0;
      end
    end
  end

endmodule

// File: tb/tb_execute_unit.sv
// Bench for execute_unit: directed vector table, hand sequences for divide/reset/hold, randomized reference checks.
module tb_execute_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dec_op1, dec_op2;
  logic [6:0]  aluctl, dec_rd, dec_branch;
  logic        dec_mre, dec_mwe, dec_jump, mem_ready;
  logic [24:0] npc;
  logic [29:0] daddr;
  logic [31:0] alu_fwd, ex_res, ex_wdata;
  logic        ex_nstall, ex_flush, ex_mre, ex_mwe;
  logic [24:0] ex_pc;
  logic [6:0]  ex_rd;
  logic [29:0] ex_daddr;

  execute_unit dut (
    .clk(clk), .rst(rst), .dec_op1(dec_op1), .dec_op2(dec_op2), .aluctl(aluctl),
    .dec_rd(dec_rd), .dec_mre(dec_mre), .dec_mwe(dec_mwe), .dec_branch(dec_branch),
    .dec_jump(dec_jump), .npc(npc), .daddr(daddr), .mem_ready(mem_ready),
    .alu_fwd(alu_fwd), .ex_nstall(ex_nstall), .ex_flush(ex_flush), .ex_pc(ex_pc),
    .ex_res(ex_res), .ex_wdata(ex_wdata), .ex_rd(ex_rd), .ex_mre(ex_mre),
    .ex_mwe(ex_mwe), .ex_daddr(ex_daddr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: arithmetic on wide integers straight from the instruction rules.
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
    longint x, y;
    if (b == 32'd0) return f[1] ? a : 32'hFFFF_FFFF;
    x = f[0] ? longint'({32'd0, a}) : longint'($signed(a));
    y = f[0] ? longint'({32'd0, b}) : longint'($signed(b));
    return f[1] ? 32'(x % y) : 32'(x / y);
  endfunction

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [6:0] ctl);
    int sa, sb, t;
    longint p;
    logic [4:0] sh;
    sa = a; sb = b; sh = b[4:0];
    p = longint'(sa) * longint'(sb);
    case (ctl[5:3])
      3'b000, 3'b100: begin
        case (ctl[2:0])
          3'd0: return (ctl[6] && ctl[5:3] == 3'b000) ? a - b : a + b;
          3'd1: return a << sh;
          3'd2: return (sa < sb) ? 32'd1 : 32'd0;
          3'd3: return (a < b) ? 32'd1 : 32'd0;
          3'd4: return a ^ b;
          3'd5: begin
            if (ctl[6]) begin t = sa >>> sh; return t; end
            return a >> sh;
          end
          3'd6: return a | b;
          default: return a & b;
        endcase
      end
      3'b001: begin
        case (ctl[2:0])
          3'd0: return 32'(p);
          3'd1: return 32'(p >>> 32);
          3'd4, 3'd5, 3'd6, 3'd7: return ref_div(a, b, ctl[2:0]);
          default: return 32'd0;
        endcase
      end
      3'b010, 3'b011: return a;
      3'b101: return (ctl[2:0] == 3'b010) ? b : a + b;
      3'b110: return 32'd0;
      default: return a + b;
    endcase
  endfunction

  function automatic logic ref_redirect(input logic [31:0] a, input logic [31:0] b,
                                        input logic [6:0] br, input logic j);
    int sa, sb;
    logic c;
    sa = a; sb = b;
    c = (br[0] && a == b) || (br[1] && a != b) || (br[2] && sa < sb) ||
        (br[3] && sa >= sb) || (br[4] && a < b) || (br[5] && a >= b);
    return (br[6] && c) || j;
  endfunction

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [6:0] ctl,
                       input logic [6:0] br, input logic j, input logic [6:0] rd);
    dec_op1 = a; dec_op2 = b; aluctl = ctl; dec_branch = br; dec_jump = j; dec_rd = rd;
  endtask

  // Runs one division through EX; optionally holds mem_ready low for 'hold' cycles in DONE.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f,
                        input logic [31:0] exp, input int hold, input string tag);
    int stalled;
    logic bubbles_ok;
    drive(a, b, {1'b0, 3'b001, f}, 7'd0, 1'b0, 7'h45);
    dec_mre = 1'b0; dec_mwe = 1'b0;
    #1;
    stalled = 0;
    bubbles_ok = 1'b1;
    while (!ex_nstall && stalled < 100) begin
      stalled++;
      @(posedge clk); #1;
      if (ex_rd != 7'd0 || ex_res != 32'd0) bubbles_ok = 1'b0;
    end
    check({tag, "_stall_cycles"}, 32'(stalled), 32'd33);
    check({tag, "_bubbles"}, 32'(bubbles_ok), 32'd1);
    if (hold > 0) begin
      mem_ready = 1'b0;
      repeat (hold) begin
        @(posedge clk); #1;
        if (ex_nstall != 1'b1 || ex_rd != 7'd0) bubbles_ok = 1'b0;
      end
      check({tag, "_done_hold"}, 32'(bubbles_ok), 32'd1);
      mem_ready = 1'b1;
      #1;
    end
    @(posedge clk); #1;
    check({tag, "_res"}, ex_res, exp);
    check({tag, "_rd"}, 32'(ex_rd), 32'h45);
    drive(32'd0, 32'd0, 7'd0, 7'd0, 1'b0, 7'd0);
    #1;
  endtask

  typedef struct {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [6:0]  ctl;
    logic [6:0]  br;
    logic        jmp;
    logic [31:0] exp_res;
    logic        exp_flush;
  } vec_t;

  vec_t vecs[21];
  logic [31:0] edge_vals[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{32'd5,        32'hFFFFFFF9, 7'h00, 7'h00, 1'b0, 32'hFFFFFFFE, 1'b0};
    vecs[1]  = '{32'd5,        32'hFFFFFFF9, 7'h40, 7'h00, 1'b0, 32'h0000000C, 1'b0};
    vecs[2]  = '{32'h80000000, 32'd4,        7'h45, 7'h00, 1'b0, 32'hF8000000, 1'b0};
    vecs[3]  = '{32'h80000000, 32'd4,        7'h05, 7'h00, 1'b0, 32'h08000000, 1'b0};
    vecs[4]  = '{32'd1,        32'h25,       7'h21, 7'h00, 1'b0, 32'h00000020, 1'b0};
    vecs[5]  = '{32'hFFFFFFFF, 32'd1,        7'h02, 7'h00, 1'b0, 32'h00000001, 1'b0};
    vecs[6]  = '{32'hFFFFFFFF, 32'd1,        7'h03, 7'h00, 1'b0, 32'h00000000, 1'b0};
    vecs[7]  = '{32'd3,        32'h12345000, 7'h2A, 7'h00, 1'b0, 32'h12345000, 1'b0};
    vecs[8]  = '{32'hFFFFFFFF, 32'd3,        7'h08, 7'h00, 1'b0, 32'hFFFFFFFD, 1'b0};
    vecs[9]  = '{32'h40000000, 32'd4,        7'h09, 7'h00, 1'b0, 32'h00000001, 1'b0};
    vecs[10] = '{32'hFFFFFFFF, 32'd1,        7'h00, 7'h44, 1'b0, 32'h00000000, 1'b1};
    vecs[11] = '{32'hFFFFFFFF, 32'd1,        7'h00, 7'h50, 1'b0, 32'h00000000, 1'b0};
    vecs[12] = '{32'hA,        32'd1,        7'h38, 7'h00, 1'b1, 32'h0000000B, 1'b1};
    vecs[13] = '{32'hF0F0F0F0, 32'hFF00FF00, 7'h04, 7'h00, 1'b0, 32'h0FF00FF0, 1'b0};
    vecs[14] = '{32'd3,        32'd4,        7'h30, 7'h00, 1'b0, 32'h00000000, 1'b0};
    vecs[15] = '{32'hDEADBEEF, 32'd4,        7'h10, 7'h00, 1'b0, 32'hDEADBEEF, 1'b0};
    vecs[16] = '{32'd3,        32'd4,        7'h0A, 7'h00, 1'b0, 32'h00000000, 1'b0};
    vecs[17] = '{32'd7,        32'd7,        7'h00, 7'h41, 1'b0, 32'h0000000E, 1'b1};
    vecs[18] = '{32'd7,        32'd7,        7'h00, 7'h01, 1'b0, 32'h0000000E, 1'b0};
    vecs[19] = '{32'hFFFFFF00, 32'd4,        7'h65, 7'h00, 1'b0, 32'hFFFFFFF0, 1'b0};
    vecs[20] = '{32'd5,        32'hFFFFFFF9, 7'h60, 7'h00, 1'b0, 32'hFFFFFFFE, 1'b0};
    edge_vals[0] = 32'h0; edge_vals[1] = 32'hFFFFFFFF; edge_vals[2] = 32'h80000000;
    edge_vals[3] = 32'h7FFFFFFF; edge_vals[4] = 32'h1; edge_vals[5] = 32'h1F;

    rst = 1'b1; mem_ready = 1'b1; dec_mre = 1'b0; dec_mwe = 1'b0;
    npc = 25'd0; daddr = 30'd0;
    drive(32'd0, 32'd0, 7'd0, 7'd0, 1'b0, 7'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_res", ex_res, 32'd0);
    check("reset_rd", 32'(ex_rd), 32'd0);
    check("reset_ctl", {28'd0, ex_mre, ex_mwe, 1'b0, ex_nstall}, 32'd1);
    rst = 1'b0;

    for (int i = 0; i < 21; i++) begin
      drive(vecs[i].op1, vecs[i].op2, vecs[i].ctl, vecs[i].br, vecs[i].jmp, 7'(7'h40 + i));
      npc = 25'(25'h100 + i);
      #1;
      check($sformatf("vec%0d_fwd", i), alu_fwd, vecs[i].exp_res);
      check($sformatf("vec%0d_flush", i), 32'(ex_flush), 32'(vecs[i].exp_flush));
      if (vecs[i].exp_flush) check($sformatf("vec%0d_pc", i), 32'(ex_pc), 32'(25'h100 + i));
      @(posedge clk); #1;
      check($sformatf("vec%0d_res", i), ex_res, vecs[i].exp_res);
      check($sformatf("vec%0d_rd", i), 32'(ex_rd), 32'(7'h40 + i));
      check($sformatf("vec%0d_wdata", i), ex_wdata, vecs[i].op2);
    end
    drive(32'd0, 32'd0, 7'd0, 7'd0, 1'b0, 7'd0);

    do_div(32'hFFFFFFF9, 32'd2, 3'b100, 32'hFFFFFFFD, 0, "div_m7_2");
    do_div(32'hFFFFFFF9, 32'd2, 3'b110, 32'hFFFFFFFF, 0, "rem_m7_2");
    do_div(32'd5, 32'd0, 3'b101, 32'hFFFFFFFF, 0, "divu_by0");
    do_div(32'hFFFFFFF9, 32'd0, 3'b110, 32'hFFFFFFF9, 0, "rem_by0");
    do_div(32'h80000000, 32'hFFFFFFFF, 3'b100, 32'h80000000, 0, "div_ovf");
    do_div(32'h80000000, 32'hFFFFFFFF, 3'b110, 32'h00000000, 0, "rem_ovf");
    do_div(32'd100, 32'd7, 3'b101, 32'h0000000E, 3, "divu_hold");

    // Reset in the middle of a divide
    drive(32'hFFFFFFF9, 32'd2, 7'h0C, 7'd0, 1'b0, 7'h45);
    #1;
    repeat (11) @(posedge clk);
    #1;
    check("rst_mid_busy", 32'(ex_nstall), 32'd0);
    rst = 1'b1;
    drive(32'd2, 32'd3, 7'h00, 7'd0, 1'b0, 7'h21);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rst_mid_nstall", 32'(ex_nstall), 32'd1);
    check("rst_mid_res", ex_res, 32'd0);
    check("rst_mid_rd", 32'(ex_rd), 32'd0);
    @(posedge clk); #1;
    check("rst_after_add_res", ex_res, 32'd5);
    check("rst_after_add_rd", 32'(ex_rd), 32'h21);

    // Store held by mem_ready=0, alongside a jump that must not flush until released
    drive(32'h1000, 32'hCAFEBABE, 7'h00, 7'd0, 1'b1, 7'h22);
    dec_mwe = 1'b1; daddr = 30'h1234567; npc = 25'h55; mem_ready = 1'b0;
    #1;
    check("hold_no_flush", 32'(ex_flush), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("hold_res", ex_res, 32'd5);
    check("hold_mwe", 32'(ex_mwe), 32'd0);
    check("hold_rd", 32'(ex_rd), 32'h21);
    mem_ready = 1'b1;
    #1;
    check("release_flush", 32'(ex_flush), 32'd1);
    check("release_pc", 32'(ex_pc), 32'h55);
    @(posedge clk); #1;
    check("release_mwe", 32'(ex_mwe), 32'd1);
    check("release_wdata", ex_wdata, 32'hCAFEBABE);
    check("release_daddr", 32'(ex_daddr), 32'h1234567);
    check("release_res", ex_res, 32'hCAFECABE);
    dec_mwe = 1'b0;

    // Randomized single-cycle ops and branches
    for (int i = 0; i < 150; i++) begin
      logic [31:0] a, b;
      logic [6:0] ctl, br;
      logic j, m;
      a = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : $urandom();
      b = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : $urandom();
      if ($urandom_range(0, 7) == 0) b = a;
      ctl = 7'($urandom());
      if (ctl[5:3] == 3'b001) ctl[2] = 1'b0;
      br = 7'd0;
      br[$urandom_range(0, 5)] = 1'b1;
      br[6] = 1'($urandom_range(0, 1));
      j = ($urandom_range(0, 3) == 0);
      m = 1'($urandom_range(0, 1));
      drive(a, b, ctl, br, j, 7'($urandom()));
      dec_mre = m;
      npc = 25'($urandom());
      #1;
      check($sformatf("rnd%0d_fwd", i), alu_fwd, ref_alu(a, b, ctl));
      check($sformatf("rnd%0d_flush", i), 32'(ex_flush), 32'(ref_redirect(a, b, br, j)));
      @(posedge clk); #1;
      check($sformatf("rnd%0d_res", i), ex_res, ref_alu(a, b, ctl));
      check($sformatf("rnd%0d_mre", i), 32'(ex_mre), 32'(m));
    end
    dec_mre = 1'b0;

    // Randomized divides
    for (int i = 0; i < 12; i++) begin
      logic [31:0] a, b;
      logic [2:0] f;
      a = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : $urandom();
      b = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 1000)) - 32'd500 : $urandom();
      f = 3'(3'd4 + 3'($urandom_range(0, 3)));
      do_div(a, b, f, ref_div(a, b, f), 0, $sformatf("rdiv%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
